// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: controller states and requester identifiers.
package ram_arbiter_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCKB = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Walks every RAM address once after a start pulse; flags busy and a done pulse.
module ram_clear_seq
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic          last
);

  assign last = busy && (count == {AW{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      done <= last;
      if (start) begin
        busy <= 1'b1;
      end else if (last) begin
        busy <= 1'b0;
      end
      // Natural wrap returns the counter to zero after the final word
      if (busy) begin
        count <= count + AW'(1);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between requesters A and B, with a whole-RAM clear sequencer.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic          b_lock,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we_n,
  input  logic [DW-1:0] ram_rdata
);

  state_t          state;
  state_t          state_next;
  port_t           last_win;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [AW-1:0]   clr_count;
  logic            clr_last;
  logic            clr_go;
  logic            a_wins;

  assign a_wins = (FIXED_PRI != 0) || (last_win == PORT_B);
  assign clr_go = (state == ST_IDLE) && clr_start;
  assign rdata  = ram_rdata;

  ram_clear_seq #(.AW(AW)) u_clear (
    .clk   (clk),
    .rst   (reset),
    .start (clr_go),
    .busy  (clr_busy),
    .done  (clr_done),
    .count (clr_count),
    .last  (clr_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_next = ST_CLEAR;
        end else if (b_gnt && b_lock) begin
          state_next = ST_LOCKB;
        end
      end
      ST_LOCKB: if (!b_lock) state_next = ST_IDLE;
      ST_CLEAR: if (clr_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Grants and RAM strobes are decoded from registered state and live requests
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    ram_we_n  = 1'b1;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (!clr_start) begin
            a_gnt = a_req && (!b_req || a_wins);
            b_gnt = b_req && !(a_req && (!b_req || a_wins));
          end
        end
        ST_LOCKB: b_gnt = b_req;
        ST_CLEAR: begin
          ram_addr  = clr_count;
          ram_wdata = '0;
          ram_we_n  = 1'b0;
        end
        default: ;
      endcase
      if (a_gnt) begin
        ram_addr  = a_addr;
        ram_wdata = a_wdata;
        ram_we_n  = !a_we;
      end else if (b_gnt) begin
        ram_addr  = b_addr;
        ram_wdata = b_wdata;
        ram_we_n  = !b_we;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_win <= PORT_B;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      addr_q   <= ram_addr;
      wdata_q  <= ram_wdata;
      if (a_gnt) begin
        last_win <= PORT_A;
      end else if (b_gnt) begin
        last_win <= PORT_B;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter, each with its own RAM model.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we, b_lock, clr_start;
  logic [7:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;

  logic       a_gnt0, a_rvalid0, b_gnt0, b_rvalid0, clr_busy0, clr_done0, ram_we_n0;
  logic [3:0] rdata0, ram_wdata0, ram_rdata0;
  logic [7:0] ram_addr0;
  logic       a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, clr_busy1, clr_done1, ram_we_n1;
  logic [3:0] rdata1, ram_wdata1, ram_rdata1;
  logic [7:0] ram_addr1;

  logic [3:0] mem0 [256];
  logic [3:0] mem1 [256];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] ref_mem [256];
  logic       m_last_a, m_locked, e_rva, e_rvb;
  logic [3:0] e_rd;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(8), .DW(4), .FIXED_PRI(0)) dut0 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt0), .a_rvalid(a_rvalid0),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt0), .b_rvalid(b_rvalid0),
    .rdata(rdata0), .clr_start(clr_start), .clr_busy(clr_busy0), .clr_done(clr_done0),
    .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_we_n(ram_we_n0), .ram_rdata(ram_rdata0)
  );

  ram_arbiter #(.AW(8), .DW(4), .FIXED_PRI(1)) dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt1), .b_rvalid(b_rvalid1),
    .rdata(rdata1), .clr_start(clr_start), .clr_busy(clr_busy1), .clr_done(clr_done1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we_n(ram_we_n1), .ram_rdata(ram_rdata1)
  );

  always @(posedge clk) begin
    if (!ram_we_n0) mem0[ram_addr0] <= ram_wdata0;
    ram_rdata0 <= mem0[ram_addr0];
    if (!ram_we_n1) mem1[ram_addr1] <= ram_wdata1;
    ram_rdata1 <= mem1[ram_addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_a = 1'b0;
    m_locked = 1'b0;
    e_rva    = 1'b0;
    e_rvb    = 1'b0;
  endtask

  task automatic check_rv();
    check("a_rvalid", 32'(a_rvalid0), 32'(e_rva));
    check("b_rvalid", 32'(b_rvalid0), 32'(e_rvb));
    if (e_rva || e_rvb) check("rdata", 32'(rdata0), 32'(e_rd));
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [3:0] ad,
                       input logic br, input logic bw, input logic [7:0] ba, input logic [3:0] bd,
                       input logic bl);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    b_lock = bl; clr_start = 1'b0;
  endtask

  // One arbitrated cycle on the round-robin instance, checked against the model
  task automatic step(input logic ar, input logic aw, input logic [7:0] aa, input logic [3:0] ad,
                      input logic br, input logic bw, input logic [7:0] ba, input logic [3:0] bd,
                      input logic bl, output logic ga, output logic gb);
    @(posedge clk); #1;
    drive(ar, aw, aa, ad, br, bw, ba, bd, bl);
    @(negedge clk);
    check_rv();
    if (m_locked) begin
      ga = 1'b0; gb = br;
    end else if (ar && br) begin
      ga = !m_last_a; gb = m_last_a;
    end else begin
      ga = ar; gb = br;
    end
    check("a_gnt", 32'(a_gnt0), 32'(ga));
    check("b_gnt", 32'(b_gnt0), 32'(gb));
    if (ga || gb) begin
      check("ram_addr", 32'(ram_addr0), 32'(ga ? aa : ba));
      check("ram_we_n", 32'(ram_we_n0), 32'(ga ? !aw : !bw));
      if (ga ? aw : bw) check("ram_wdata", 32'(ram_wdata0), 32'(ga ? ad : bd));
    end else begin
      check("ram_we_n_idle", 32'(ram_we_n0), 32'(1'b1));
    end
    e_rva = ga && !aw;
    e_rvb = gb && !bw;
    e_rd  = ref_mem[ga ? aa : ba];
    if (ga && aw) ref_mem[aa] = ad;
    if (gb && bw) ref_mem[ba] = bd;
    if (m_locked) m_locked = bl;
    else if (gb && bl) m_locked = 1'b1;
    if (ga) m_last_a = 1'b1;
    else if (gb) m_last_a = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h01, 4'h0, 1'b1, 1'b0, 8'h02, 4'h0, 1'b0);
    @(negedge clk);
    check("rst_a_gnt", 32'(a_gnt0), 32'(1'b0));
    check("rst_b_gnt", 32'(b_gnt0), 32'(1'b0));
    check("rst_a_rvalid", 32'(a_rvalid0), 32'(1'b0));
    check("rst_b_rvalid", 32'(b_rvalid0), 32'(1'b0));
    check("rst_clr_busy", 32'(clr_busy0), 32'(1'b0));
    check("rst_clr_done", 32'(clr_done0), 32'(1'b0));
    check("rst_ram_we_n", 32'(ram_we_n0), 32'(1'b1));
    check("rst_a_gnt_fixed", 32'(a_gnt1), 32'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    model_reset();
  endtask

  // Clear sequence; abort_at < 256 asserts reset while that word is being driven
  task automatic do_clear(input int abort_at);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'h05, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    clr_start = 1'b1;
    @(negedge clk);
    check_rv();
    check("clr_start_no_gnt", 32'(a_gnt0), 32'(1'b0));
    check("clr_start_busy", 32'(clr_busy0), 32'(1'b0));
    check("clr_start_we_n", 32'(ram_we_n0), 32'(1'b1));
    e_rva = 1'b0; e_rvb = 1'b0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      clr_start = (k == 50);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_we_n", 32'(ram_we_n0), 32'(1'b1));
        check("abort_busy", 32'(clr_busy0), 32'(1'b0));
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        model_reset();
        for (int j = 0; j < k; j++) ref_mem[j] = 4'h0;
        return;
      end
      @(negedge clk);
      check("clr_busy", 32'(clr_busy0), 32'(1'b1));
      check("clr_addr", 32'(ram_addr0), 32'(k));
      check("clr_we_n", 32'(ram_we_n0), 32'(1'b0));
      check("clr_wdata", 32'(ram_wdata0), 32'(4'h0));
      check("clr_no_gnt", 32'(a_gnt0), 32'(1'b0));
      check("clr_done_early", 32'(clr_done0), 32'(1'b0));
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    @(negedge clk);
    check("clr_busy_end", 32'(clr_busy0), 32'(1'b0));
    check("clr_done", 32'(clr_done0), 32'(1'b1));
    check("clr_end_we_n", 32'(ram_we_n0), 32'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    check("clr_done_pulse", 32'(clr_done0), 32'(1'b0));
    for (int j = 0; j < 256; j++) ref_mem[j] = 4'h0;
  endtask

  initial begin
    logic       ga, gb, pa, pb, aw_r, bw_r, bl_r;
    logic [7:0] aa_r, ba_r;
    logic [3:0] ad_r, bd_r;

    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    model_reset();
    #2;
    reset_dut();

    // A write then read of 0x10
    step(1'b1, 1'b1, 8'h10, 4'h5, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    step(1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    check("addr_hold", 32'(ram_addr0), 32'(8'h10));

    // Fill with 0xF, clear, read back zeros
    for (int i = 0; i < 256; i++)
      step(1'b1, 1'b1, 8'(i), 4'hF, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    step(1'b1, 1'b0, 8'h20, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    do_clear(256);
    for (int i = 0; i < 256; i++)
      step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'(i), 4'h0, 1'b0, ga, gb);

    // Random traffic; requests stay stable until granted
    pa = 1'b0; pb = 1'b0;
    aw_r = 1'b0; bw_r = 1'b0; aa_r = '0; ba_r = '0; ad_r = '0; bd_r = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pa) begin
        pa = 1'($urandom_range(0, 1)); aw_r = 1'($urandom_range(0, 1));
        aa_r = 8'($urandom_range(0, 15)); ad_r = 4'($urandom_range(0, 15));
      end
      if (!pb) begin
        pb = 1'($urandom_range(0, 1)); bw_r = 1'($urandom_range(0, 1));
        ba_r = 8'($urandom_range(0, 15)); bd_r = 4'($urandom_range(0, 15));
      end
      bl_r = ($urandom_range(0, 3) == 0);
      step(pa, aw_r, aa_r, ad_r, pb, bw_r, ba_r, bd_r, bl_r, ga, gb);
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
    end
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);

    // B lock with A contending
    step(1'b1, 1'b0, 8'h01, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 8'h02, 4'h0, 1'b1, 1'b0, 8'(i), 4'h0, 1'b1, ga, gb);
    step(1'b1, 1'b0, 8'h02, 4'h0, 1'b1, 1'b0, 8'h07, 4'h0, 1'b0, ga, gb);
    step(1'b1, 1'b0, 8'h02, 4'h0, 1'b1, 1'b0, 8'h08, 4'h0, 1'b0, ga, gb);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h08, 4'h0, 1'b0, ga, gb);

    // Round-robin back-to-back reads from both ports
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 8'(i), 4'h0, 1'b1, 1'b0, 8'(i + 8), 4'h0, 1'b0, ga, gb);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);

    // Fixed priority instance starved of B while A requests
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(i), 4'h0, 1'b1, 1'b0, 8'(i + 8), 4'h0, 1'b0, ga, gb);
      check("fix_a_gnt", 32'(a_gnt1), 32'(1'b1));
      check("fix_b_gnt", 32'(b_gnt1), 32'(1'b0));
      check("fix_a_rvalid", 32'(a_rvalid1), 32'(i > 0));
    end
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h09, 4'h0, 1'b0, ga, gb);
    check("fix_b_alone", 32'(b_gnt1), 32'(1'b1));
    check("fix_b_rvalid", 32'(b_rvalid1), 32'(1'b0));

    // Reset in the middle of a clear leaves the upper words untouched
    for (int i = 0; i < 256; i++)
      step(1'b1, 1'b1, 8'(i), 4'hF, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    do_clear(100);
    for (int i = 0; i < 256; i++)
      step(1'b1, 1'b0, 8'(i), 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ga, gb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
